// File: rtl/scs8hd_a311oi_bist_ctrl.sv
// Self-test sequencer for one scs8hd_a311oi cell: walks all 32 input vectors,
// compares Y_DUT against !((A1&A2&A3)|B1|C1) and records pass/fail results.
module scs8hd_a311oi_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RESETB,
    input  logic       START,
    input  logic       ABORT,
    input  logic       Y_DUT,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic       B1,
    output logic       C1,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [5:0] FAIL_CNT,
    output logic       FAIL_VALID,
    output logic [4:0] FAIL_VEC
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

    state_e     r_state, w_state_d;
    logic [4:0] r_vec, w_vec_d;
    logic [3:0] r_cnt, w_cnt_d;
    logic       r_busy, w_busy_d;
    logic       r_done, w_done_d;
    logic       r_pass, w_pass_d;
    logic [5:0] r_fail_cnt, w_fail_cnt_d;
    logic       r_fail_valid, w_fail_valid_d;
    logic [4:0] r_fail_vec, w_fail_vec_d;
    logic       w_exp;
    logic       w_mismatch;

    assign w_exp      = ~((&r_vec[2:0]) | r_vec[3] | r_vec[4]);
    assign w_mismatch = Y_DUT ^ w_exp;

    always_comb begin
        w_state_d      = r_state;
        w_vec_d        = r_vec;
        w_cnt_d        = r_cnt;
        w_busy_d       = r_busy;
        w_done_d       = 1'b0;
        w_pass_d       = r_pass;
        w_fail_cnt_d   = r_fail_cnt;
        w_fail_valid_d = r_fail_valid;
        w_fail_vec_d   = r_fail_vec;
        unique case (r_state)
            StIdle: begin
                if (START && !ABORT) begin
                    w_state_d      = StRun;
                    w_vec_d        = 5'd0;
                    w_cnt_d        = 4'd0;
                    w_busy_d       = 1'b1;
                    w_pass_d       = 1'b0;
                    w_fail_cnt_d   = 6'd0;
                    w_fail_valid_d = 1'b0;
                    w_fail_vec_d   = 5'd0;
                end
            end
            StRun: begin
                if (ABORT) begin
                    // Partial failure results are kept for inspection.
                    w_state_d = StIdle;
                    w_vec_d   = 5'd0;
                    w_cnt_d   = 4'd0;
                    w_busy_d  = 1'b0;
                    w_pass_d  = 1'b0;
                end else if (r_cnt != LP_SETTLE) begin
                    w_cnt_d = r_cnt + 4'd1;
                end else begin
                    w_cnt_d = 4'd0;
                    if (w_mismatch) begin
                        w_fail_cnt_d = r_fail_cnt + 6'd1;
                        if (!r_fail_valid) begin
                            w_fail_valid_d = 1'b1;
                            w_fail_vec_d   = r_vec;
                        end
                    end
                    if (r_vec == 5'd31) begin
                        w_state_d = StDone;
                        w_vec_d   = 5'd0;
                        w_busy_d  = 1'b0;
                        w_done_d  = 1'b1;
                        w_pass_d  = (w_fail_cnt_d == 6'd0);
                    end else begin
                        w_vec_d = r_vec + 5'd1;
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
                w_vec_d   = 5'd0;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_state      <= StIdle;
            r_vec        <= 5'd0;
            r_cnt        <= 4'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_cnt   <= 6'd0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= 5'd0;
        end else begin
            r_state      <= w_state_d;
            r_vec        <= w_vec_d;
            r_cnt        <= w_cnt_d;
            r_busy       <= w_busy_d;
            r_done       <= w_done_d;
            r_pass       <= w_pass_d;
            r_fail_cnt   <= w_fail_cnt_d;
            r_fail_valid <= w_fail_valid_d;
            r_fail_vec   <= w_fail_vec_d;
        end
    end

    // The vector register is held at zero outside RUN, so it drives the cell directly.
    assign A1         = r_vec[0];
    assign A2         = r_vec[1];
    assign A3         = r_vec[2];
    assign B1         = r_vec[3];
    assign C1         = r_vec[4];
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign PASS       = r_pass;
    assign FAIL_CNT   = r_fail_cnt;
    assign FAIL_VALID = r_fail_valid;
    assign FAIL_VEC   = r_fail_vec;

endmodule

// File: tb/tb_scs8hd_a311oi_bist_ctrl.sv
// Bench for scs8hd_a311oi_bist_ctrl: two instances (settle 1 and 0) driving a
// table-based cell model; results checked against a vector-level reference.
module tb_scs8hd_a311oi_bist_ctrl;

    logic        clk = 1'b0;
    logic        rstb;
    logic        start0, start1, abort;
    logic [31:0] tbl;

    logic [4:0] drv0, drv1;
    logic       busy0, busy1, done0, done1, pass0, pass1, fv0, fv1;
    logic [5:0] fcnt0, fcnt1;
    logic [4:0] fvec0, fvec1;
    logic       y0, y1;

    int n_tests = 0;
    int n_fail  = 0;
    bit sel;

    logic       s_busy, s_done, s_pass, s_fv;
    logic [4:0] s_drv, s_fvec;
    logic [5:0] s_fcnt;

    always #5 clk = ~clk;

    assign y0 = tbl[drv0];
    assign y1 = tbl[drv1];

    always_comb begin
        if (sel) begin
            s_busy = busy1; s_done = done1; s_pass = pass1; s_fv = fv1;
            s_drv  = drv1;  s_fvec = fvec1; s_fcnt = fcnt1;
        end else begin
            s_busy = busy0; s_done = done0; s_pass = pass0; s_fv = fv0;
            s_drv  = drv0;  s_fvec = fvec0; s_fcnt = fcnt0;
        end
    end

    scs8hd_a311oi_bist_ctrl #(.SETTLE_CYCLES(0)) u_dut0 (
        .CLK(clk), .RESETB(rstb), .START(start0), .ABORT(abort), .Y_DUT(y0),
        .A1(drv0[0]), .A2(drv0[1]), .A3(drv0[2]), .B1(drv0[3]), .C1(drv0[4]),
        .BUSY(busy0), .DONE(done0), .PASS(pass0), .FAIL_CNT(fcnt0),
        .FAIL_VALID(fv0), .FAIL_VEC(fvec0)
    );

    scs8hd_a311oi_bist_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .CLK(clk), .RESETB(rstb), .START(start1), .ABORT(abort), .Y_DUT(y1),
        .A1(drv1[0]), .A2(drv1[1]), .A3(drv1[2]), .B1(drv1[3]), .C1(drv1[4]),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .FAIL_CNT(fcnt1),
        .FAIL_VALID(fv1), .FAIL_VEC(fvec1)
    );

    // Cell function from its inputs: vec = {C1,B1,A3,A2,A1}.
    function automatic bit golden(input int k);
        return !((k % 8 == 7) || ((k / 8) % 2 == 1) || (k >= 16));
    endfunction

    function automatic bit no_b1(input int k);
        return !((k % 8 == 7) || (k >= 16));
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int d, input bit v);
        if (d == 1) start1 = v;
        else start0 = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy0"}, busy0, 0);  check({tag, " busy1"}, busy1, 0);
        check({tag, " drv0"}, drv0, 0);    check({tag, " drv1"}, drv1, 0);
        check({tag, " done1"}, done1, 0);  check({tag, " pass1"}, pass1, 0);
        check({tag, " fcnt1"}, fcnt1, 0);  check({tag, " fv1"}, fv1, 0);
        check({tag, " fvec1"}, fvec1, 0);  check({tag, " fcnt0"}, fcnt0, 0);
    endtask

    // One run on instance d (settle = d). abort_n >= 0 raises ABORT in busy
    // cycle abort_n; noise pulses START during the run; abort_done raises ABORT in DONE.
    task automatic run(input string tag, input int d, input int abort_n,
                       input bit noise, input bit abort_done);
        int  hold = d + 1;
        int  len  = 32 * hold;
        int  ecnt = 0;
        int  efirst = 0;
        bit  evalid = 0;
        sel = (d == 1);
        for (int k = 0; k < 32; k++) begin
            if ((abort_n < 0 || (k + 1) * hold <= abort_n) && tbl[k] != golden(k)) begin
                if (!evalid) efirst = k;
                evalid = 1;
                ecnt++;
            end
        end
        @(negedge clk);
        set_start(d, 1'b1);
        @(negedge clk);
        set_start(d, 1'b0);
        for (int n = 0; n <= len; n++) begin
            if (n < len) begin
                check({tag, " busy"}, s_busy, 1);
                check({tag, " vec"}, s_drv, n / hold);
                check({tag, " done_early"}, s_done, 0);
            end else begin
                check({tag, " busy_end"}, s_busy, 0);
                check({tag, " done"}, s_done, 1);
                check({tag, " vec_end"}, s_drv, 0);
                check({tag, " pass"}, s_pass, ecnt == 0);
                check({tag, " fail_cnt"}, s_fcnt, ecnt);
                check({tag, " fail_valid"}, s_fv, evalid);
                check({tag, " fail_vec"}, s_fvec, efirst);
            end
            if (n == abort_n) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check({tag, " abort_busy"}, s_busy, 0);
                check({tag, " abort_vec"}, s_drv, 0);
                check({tag, " abort_done"}, s_done, 0);
                check({tag, " abort_pass"}, s_pass, 0);
                check({tag, " abort_cnt"}, s_fcnt, ecnt);
                check({tag, " abort_valid"}, s_fv, evalid);
                check({tag, " abort_fvec"}, s_fvec, efirst);
                @(negedge clk);
                check({tag, " abort_stay"}, s_busy, 0);
                return;
            end
            set_start(d, noise && (n % 9 == 4));
            if (abort_done && n == len) abort = 1'b1;
            @(negedge clk);
        end
        set_start(d, 1'b0);
        abort = 1'b0;
        check({tag, " done_pulse"}, s_done, 0);
        check({tag, " idle_busy"}, s_busy, 0);
        check({tag, " hold_cnt"}, s_fcnt, ecnt);
        check({tag, " hold_pass"}, s_pass, ecnt == 0);
        @(negedge clk);
        check({tag, " no_restart"}, s_busy, 0);
        check({tag, " hold_vec"}, s_fvec, efirst);
    endtask

    initial begin
        logic [31:0] t;
        rstb   = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        abort  = 1'b0;
        sel    = 1'b1;
        t = '0;
        for (int k = 0; k < 32; k++) t[k] = golden(k);
        tbl = t;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rstb = 1'b1;

        run("golden_s1", 1, -1, 1'b0, 1'b0);
        tbl = 32'h0;
        run("stuck0", 1, -1, 1'b0, 1'b0);
        check("stuck0 cnt7", fcnt1, 7);
        tbl = 32'hffff_ffff;
        run("stuck1", 1, -1, 1'b0, 1'b0);
        check("stuck1 vec7", fvec1, 7);
        for (int k = 0; k < 32; k++) t[k] = no_b1(k);
        tbl = t;
        run("no_b1", 1, -1, 1'b0, 1'b0);
        check("no_b1 vec8", fvec1, 8);

        tbl = 32'h0;
        run("abort_v10", 1, 20, 1'b0, 1'b0);
        for (int k = 0; k < 32; k++) t[k] = golden(k);
        tbl = t;
        run("start_noise", 1, -1, 1'b1, 1'b1);

        for (int i = 0; i < 4; i++) begin
            tbl = $urandom();
            run("random", i % 2, -1, 1'b0, 1'b0);
        end

        // Reset mid-run after a failing run, then a settle-0 golden run.
        tbl = 32'hffff_ffff;
        sel = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset busy", busy1, 1);
        #2 rstb = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        @(negedge clk);
        check_all_zero("held_reset");
        rstb = 1'b1;
        for (int k = 0; k < 32; k++) t[k] = golden(k);
        tbl = t;
        run("golden_s0", 0, -1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
